// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Imported by the receiver top and its FIFO.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP,
        UART_BREAK
    } uart_state_t;

    // Width of a down-counter that must hold clks-1.
    function automatic int uart_cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO for the UART receiver.
// Pointer pair plus occupancy counter; full-with-pop accepts the write.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rd_ok;
    logic          wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a valid/ready byte stream.
// Holds synchronizer, deframing FSM, counters and overrun flag.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 416,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clear_overrun,
    output logic       busy
);

    localparam int CW = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t   state;
    logic          rx_m;
    logic          rx_s;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [7:0]    shreg;
    logic          tick;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;

    assign tick          = (cyc_cnt == '0);
    assign push          = (state == UART_STOP) && tick && rx_s;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = !empty;

    // Two-flop synchronizer; idles high so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Deframing FSM with its bit/cycle counters and registered flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= UART_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            shreg     <= '0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                UART_IDLE: begin
                    if (!rx_s) begin
                        state   <= UART_START;
                        busy    <= 1'b1;
                        cyc_cnt <= HALF_M1;
                    end
                end
                UART_START: begin
                    if (!tick) begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= UART_DATA;
                        cyc_cnt <= FULL_M1;
                        bit_cnt <= '0;
                    end else begin
                        state <= UART_IDLE;
                        busy  <= 1'b0;
                    end
                end
                UART_DATA: begin
                    if (!tick) begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cyc_cnt <= FULL_M1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= UART_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                UART_STOP: begin
                    if (!tick) begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= UART_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state     <= UART_BREAK;
                        frame_err <= 1'b1;
                    end
                end
                UART_BREAK: begin
                    if (rx_s) begin
                        state <= UART_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= UART_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: a dropped byte beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (push),
        .wr_data(shreg),
        .rd_en  (pop),
        .rd_data(m_axis_tdata),
        .empty  (empty),
        .full   (full)
    );

endmodule

// File: doc/uart_rx_stream.md
# uart_rx_stream

Serial-to-stream receiver feeding the USB bridge's IN path inside the user project. It samples the `mprj_io[34]` UART line at a fixed baud rate and deframes 8N1 characters. Received bytes are buffered in a small FIFO and presented on a valid/ready byte stream that the USB bridge consumes as `in_data`/`in_valid`/`in_ready`. It also flags framing errors and FIFO overruns.

## Interface
- `CLKS_PER_BIT`, 416, clock cycles per UART bit (48 MHz / 115200); legal range ≥ 8.
- `FIFO_DEPTH`, 4, bytes of buffering; power of two, ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous UART line, idle high.
- `m_axis_tdata`  out  8  received byte, head of the FIFO.
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  consumer accepts the byte when `tvalid & tready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1  sticky; set when a completed byte is dropped because the FIFO is full.
- `clear_overrun`  in  1  clears `overrun`; a set event in the same cycle wins.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK. A bit counter (0..7) and a cycle counter of width clog2(CLKS_PER_BIT) support it.
- IDLE: when `rx_s` is 0, load cycle count and go to START.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If `rx_s` is 0, go to DATA. If 1, treat as a glitch and return to IDLE with no output and no error.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After bit 7, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - `rx_s` = 1: push the byte to the FIFO, go to IDLE.
  - `rx_s` = 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: stay until `rx_s` is 1, then go to IDLE. This prevents a held-low line from retriggering.
- FIFO is first-word fall-through: `m_axis_tdata` shows the head entry whenever `tvalid` is 1. Pop occurs on `tvalid & tready`.
- Push when full without a pop in the same cycle: drop the byte and set `overrun`.
- Push when full with a pop in the same cycle: accept the push, leave occupancy unchanged, do not set overrun.
- Push and pop on an empty FIFO do not bypass; the pushed byte appears the next cycle.
- `m_axis_tdata` is stable while `tvalid & !tready`.
- Reset outputs: `m_axis_tvalid`=0, `m_axis_tdata`=0, `frame_err`=0, `overrun`=0, `busy`=0. FIFO empties, FSM enters IDLE.
- Reset mid-frame abandons the frame. After reset, the next falling edge starts a fresh frame.

## Timing
- Let T0 be the cycle `rx_s` is first seen low in IDLE (two cycles after the pin edge).
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit n sample: T0 + CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. The FIFO write and the `frame_err` pulse occur in this cycle.
- `m_axis_tvalid` rises one cycle after the stop sample. With defaults that is 3953 cycles after T0, or 3955 cycles after the pin edge.
- `busy` is high from T0+1 until the cycle after IDLE is re-entered.
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is detected.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`, `UART_BREAK`.
  - `UART_DATA_BITS` = 8.
  - Function to compute counter width from CLKS_PER_BIT.
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO with parameter DEPTH.
  - Ports: `clk`, `rst_n`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`.
  - Built on a registered pointer pair plus an occupancy counter.
- The top level holds the synchronizer, FSM, counters and overrun flag.

## Test plan
- Bytes 0x00..0x07 at 416 cycles/bit with `tready`=1: each byte appears once, in order, with `tvalid` 3955 cycles after its start edge. No `frame_err`, no `overrun`.
- 100-cycle low glitch on `rx`: no `tvalid`, no `frame_err`. `busy` returns to 0 within 210 cycles.
- 0x55 sent with stop bit low and the line held low 2000 cycles: one `frame_err` pulse, no `tvalid`, `busy` held until `rx` rises. A following 0xA3 is received correctly.
- `tready`=0, send 0x10..0x14: FIFO holds 0x10..0x13 with 0x10 stable on `tdata`, and `overrun`=1 after the fifth stop bit. Draining yields exactly 0x10..0x13. `clear_overrun` then returns `overrun` to 0.
- FIFO full, pop asserted in the stop-sample cycle of a new byte: byte accepted, `overrun` stays 0, drain order preserved.
- `rst_n` low for one cycle during data bit 4 of 0xFF: all outputs at their reset values. The next frame, 0x3C, is received correctly.
